// File: rtl/arcade_input_decoder.sv
// arcade_input_decoder
//   Input-conditioning stage in front of the game core. Decodes hps_io PS/2
//   key events into per-key latches, merges them with both joystick words
//   and drives registered player controls, start lines and a coin line that
//   is stretched to a fixed COIN_PULSE_CYCLES-wide pulse.
//
//   Optional feature macro: ARCADE_INPUT_DECODER_AUTOFIRE_EN
//     When defined, adds the autofire_on input and a free-running square wave
//     (half-period AUTOFIRE_DIV cycles) that gates fire1/fire2 while
//     autofire_on is high. When undefined, fire outputs are the plain merge.
//
//   Latency: joystick change -> outputs on the next edge; PS/2 event ->
//   key latch on the next edge, outputs one edge later.
module arcade_input_decoder #(
  parameter int COIN_PULSE_CYCLES = 200000,
  parameter int AUTOFIRE_DIV      = 1200000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
  input  logic        autofire_on,
`endif
  output logic        up1,
  output logic        down1,
  output logic        left1,
  output logic        right1,
  output logic        fire1,
  output logic        up2,
  output logic        down2,
  output logic        left2,
  output logic        right2,
  output logic        fire2,
  output logic        start1,
  output logic        start2,
  output logic        coin1
);

  // ---------------------------------------------------------------------
  // Key latch indices. Keys sharing an output line keep separate latches
  // so the line stays asserted while any of them is held.
  // ---------------------------------------------------------------------
  localparam int NK = 17;
  localparam logic [4:0] K_UP1     = 5'd0;
  localparam logic [4:0] K_DOWN1   = 5'd1;
  localparam logic [4:0] K_LEFT1   = 5'd2;
  localparam logic [4:0] K_RIGHT1  = 5'd3;
  localparam logic [4:0] K_FIRE1A  = 5'd4;
  localparam logic [4:0] K_FIRE1B  = 5'd5;
  localparam logic [4:0] K_START1A = 5'd6;
  localparam logic [4:0] K_START1B = 5'd7;
  localparam logic [4:0] K_START2A = 5'd8;
  localparam logic [4:0] K_START2B = 5'd9;
  localparam logic [4:0] K_COINA   = 5'd10;
  localparam logic [4:0] K_COINB   = 5'd11;
  localparam logic [4:0] K_UP2     = 5'd12;
  localparam logic [4:0] K_DOWN2   = 5'd13;
  localparam logic [4:0] K_LEFT2   = 5'd14;
  localparam logic [4:0] K_RIGHT2  = 5'd15;
  localparam logic [4:0] K_FIRE2   = 5'd16;

  // Coin stretcher states.
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PULSE    = 2'd1;
  localparam logic [1:0] S_WAIT_LOW = 2'd2;

  localparam int CW = $clog2(COIN_PULSE_CYCLES + 1);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE_CYCLES - 1);

  // Registered control lines (coin1 lives in the coin stretcher).
  typedef struct packed {
    logic up1;
    logic down1;
    logic left1;
    logic right1;
    logic fire1;
    logic up2;
    logic down2;
    logic left2;
    logic right2;
    logic fire2;
    logic start1;
    logic start2;
  } ctl_t;

  logic          armed_q, armed_d;
  logic          old_toggle_q, old_toggle_d;
  logic [NK-1:0] key_q, key_d;
  logic          key_hit;
  logic [4:0]    key_idx;
  logic          ext;
  logic [7:0]    scancode;
  logic [15:0]   jm;
  ctl_t          ctl_q, ctl_d;
  logic          coin_raw_q, coin_raw_d;
  logic          coin_prev_q, coin_prev_d;
  logic [1:0]    coin_state_q, coin_state_d;
  logic [CW-1:0] coin_cnt_q, coin_cnt_d;
  logic          coin1_q, coin1_d;
  logic          fire_gate;
  logic          unused_jm;

  assign ext      = ps2_key[8];
  assign scancode = ps2_key[7:0];
  assign jm       = joystick_0 | joystick_1;
  // Upper joystick bits carry no function on this core.
  assign unused_jm = ^jm[15:8];

  // Map {extended, scancode} to a key latch; bit 8 is ignored for the
  // player-1 directions and the X14 fire key.
  always_comb begin
    key_hit = 1'b0;
    key_idx = K_UP1;
    case (scancode)
      8'h75: begin key_hit = 1'b1; key_idx = K_UP1;     end
      8'h72: begin key_hit = 1'b1; key_idx = K_DOWN1;   end
      8'h6B: begin key_hit = 1'b1; key_idx = K_LEFT1;   end
      8'h74: begin key_hit = 1'b1; key_idx = K_RIGHT1;  end
      8'h14: begin key_hit = 1'b1; key_idx = K_FIRE1B;  end
      8'h29: begin key_hit = ~ext; key_idx = K_FIRE1A;  end
      8'h05: begin key_hit = ~ext; key_idx = K_START1A; end
      8'h16: begin key_hit = ~ext; key_idx = K_START1B; end
      8'h06: begin key_hit = ~ext; key_idx = K_START2A; end
      8'h1E: begin key_hit = ~ext; key_idx = K_START2B; end
      8'h2E: begin key_hit = ~ext; key_idx = K_COINA;   end
      8'h36: begin key_hit = ~ext; key_idx = K_COINB;   end
      8'h2D: begin key_hit = ~ext; key_idx = K_UP2;     end
      8'h2B: begin key_hit = ~ext; key_idx = K_DOWN2;   end
      8'h23: begin key_hit = ~ext; key_idx = K_LEFT2;   end
      8'h34: begin key_hit = ~ext; key_idx = K_RIGHT2;  end
      8'h1C: begin key_hit = ~ext; key_idx = K_FIRE2;   end
      default: begin key_hit = 1'b0; key_idx = K_UP1;   end
    endcase
  end

  // Arm on the first edge after reset, then decode one toggle event per edge.
  always_comb begin
    armed_d      = armed_q;
    old_toggle_d = old_toggle_q;
    key_d        = key_q;
    if (!armed_q) begin
      // Sync to whatever toggle level is present; never decode here.
      armed_d      = 1'b1;
      old_toggle_d = ps2_key[10];
    end else if (ps2_key[10] != old_toggle_q) begin
      old_toggle_d = ps2_key[10];
      if (key_hit) begin
        key_d[key_idx] = ps2_key[9];
      end
    end
  end

  // Event-detect and key latch state.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      armed_q      <= 1'b0;
      old_toggle_q <= 1'b0;
      key_q        <= '0;
    end else begin
      armed_q      <= armed_d;
      old_toggle_q <= old_toggle_d;
      key_q        <= key_d;
    end
  end

`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
  localparam int AW = $clog2(AUTOFIRE_DIV + 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 1);

  logic [AW-1:0] af_cnt_q, af_cnt_d;
  logic          af_phase_q, af_phase_d;

  // Free-running divider; the phase flips every AUTOFIRE_DIV cycles.
  always_comb begin
    af_cnt_d   = af_cnt_q + 1'b1;
    af_phase_d = af_phase_q;
    if (af_cnt_q == AF_LAST) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
    fire_gate = autofire_on ? af_phase_q : 1'b1;
  end

  // Autofire divider state; phase starts high so fire is live right away.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end
`else
  localparam logic unused_af_div = (AUTOFIRE_DIV > 0);
  assign fire_gate = 1'b1;
`endif

  // Merge key latches with the OR of both pads.
  always_comb begin
    ctl_d        = '0;
    ctl_d.up1    = key_q[K_UP1]    | jm[3];
    ctl_d.down1  = key_q[K_DOWN1]  | jm[2];
    ctl_d.left1  = key_q[K_LEFT1]  | jm[1];
    ctl_d.right1 = key_q[K_RIGHT1] | jm[0];
    ctl_d.fire1  = (key_q[K_FIRE1A] | key_q[K_FIRE1B] | jm[4]) & fire_gate;
    ctl_d.up2    = key_q[K_UP2]    | jm[3];
    ctl_d.down2  = key_q[K_DOWN2]  | jm[2];
    ctl_d.left2  = key_q[K_LEFT2]  | jm[1];
    ctl_d.right2 = key_q[K_RIGHT2] | jm[0];
    ctl_d.fire2  = (key_q[K_FIRE2] | jm[4]) & fire_gate;
    ctl_d.start1 = key_q[K_START1A] | key_q[K_START1B] | jm[5];
    ctl_d.start2 = key_q[K_START2A] | key_q[K_START2B] | jm[6];
    coin_raw_d   = key_q[K_COINA] | key_q[K_COINB] | jm[7];
    coin_prev_d  = coin_raw_q;
  end

  // Output register stage for control lines plus the coin request history.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ctl_q       <= '0;
      coin_raw_q  <= 1'b0;
      coin_prev_q <= 1'b0;
    end else begin
      ctl_q       <= ctl_d;
      coin_raw_q  <= coin_raw_d;
      coin_prev_q <= coin_prev_d;
    end
  end

  // Coin stretcher: a rising request starts one fixed-width pulse; requests
  // during the pulse are ignored and a held request must drop before rearming.
  always_comb begin
    coin_state_d = coin_state_q;
    coin_cnt_d   = coin_cnt_q;
    coin1_d      = coin1_q;
    case (coin_state_q)
      S_IDLE: begin
        if (coin_raw_q && !coin_prev_q) begin
          coin_cnt_d   = COIN_LOAD;
          coin1_d      = 1'b1;
          coin_state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (coin_cnt_q == '0) begin
          coin1_d      = 1'b0;
          coin_state_d = coin_raw_q ? S_WAIT_LOW : S_IDLE;
        end else begin
          coin_cnt_d = coin_cnt_q - 1'b1;
        end
      end
      S_WAIT_LOW: begin
        if (!coin_raw_q) begin
          coin_state_d = S_IDLE;
        end
      end
      default: begin
        coin1_d      = 1'b0;
        coin_state_d = S_IDLE;
      end
    endcase
  end

  // Coin stretcher state; reset aborts any pulse in flight.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      coin_state_q <= S_IDLE;
      coin_cnt_q   <= '0;
      coin1_q      <= 1'b0;
    end else begin
      coin_state_q <= coin_state_d;
      coin_cnt_q   <= coin_cnt_d;
      coin1_q      <= coin1_d;
    end
  end

  assign up1    = ctl_q.up1;
  assign down1  = ctl_q.down1;
  assign left1  = ctl_q.left1;
  assign right1 = ctl_q.right1;
  assign fire1  = ctl_q.fire1;
  assign up2    = ctl_q.up2;
  assign down2  = ctl_q.down2;
  assign left2  = ctl_q.left2;
  assign right2 = ctl_q.right2;
  assign fire2  = ctl_q.fire2;
  assign start1 = ctl_q.start1;
  assign start2 = ctl_q.start2;
  assign coin1  = coin1_q;

endmodule

// File: tb/tb_arcade_input_decoder.sv
// Bench for arcade_input_decoder: directed and random stimulus, a reference
// model that pushes the expected output word per clock edge, and a monitor
// that pops and compares after every edge.
module tb_arcade_input_decoder;

  localparam int COIN_N = 8;
  localparam int AF_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic up1, down1, left1, right1, fire1;
  logic up2, down2, left2, right2, fire2;
  logic start1, start2, coin1;
`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
  logic autofire_on;
  logic nx_af;
`endif

  logic [10:0] nx_ps2;
  logic [15:0] nx_j0, nx_j1;
  logic [31:0] ra, rb;

  logic [12:0] act;
  assign act = {up1, down1, left1, right1, fire1, up2, down2, left2, right2,
                fire2, start1, start2, coin1};

  arcade_input_decoder #(
    .COIN_PULSE_CYCLES(COIN_N),
    .AUTOFIRE_DIV     (AF_DIV)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
    .autofire_on(autofire_on),
`endif
    .up1        (up1),
    .down1      (down1),
    .left1      (left1),
    .right1     (right1),
    .fire1      (fire1),
    .up2        (up2),
    .down2      (down2),
    .left2      (left2),
    .right2     (right2),
    .fire2      (fire2),
    .start1     (start1),
    .start2     (start2),
    .coin1      (coin1)
  );

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  int n_chk = 0;
  int n_bad = 0;
  int mon_cyc = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, mon_cyc, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: one expected word per clock edge, compared 2 time units after it.
  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      if (mon_en) begin
        mon_cyc++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL queue_underflow cycle=%0d got=%b want=none", mon_cyc, act);
        end else begin
          check("outputs", act, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Key table: {ext,code}, whether ext is don't-care, and the output bit it
  // drives in act (-1 for the coin keys).
  logic [8:0] tab_code [17] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h029, 9'h014,
                                9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036,
                                9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C};
  bit tab_anyx [17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int tab_bit [17] = '{12, 11, 10, 9, 8, 8, 2, 2, 1, 1, -1, -1, 7, 6, 5, 4, 3};
  logic [8:0] pool [27] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B,
                            9'h074, 9'h174, 9'h029, 9'h014, 9'h114, 9'h005,
                            9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036, 9'h02D,
                            9'h02B, 9'h023, 9'h034, 9'h01C, 9'h0FF, 9'h129,
                            9'h11C, 9'h000, 9'h15A};

  bit m_lat [17];
  bit m_armed, m_old, m_r1, m_r2, m_coin_prev;
  int m_left, m_edges;

  function automatic int lookup(input logic [8:0] c);
    for (int i = 0; i < 17; i++) begin
      if (tab_anyx[i] ? (c[7:0] == tab_code[i][7:0]) : (c == tab_code[i]))
        return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 17; i++) m_lat[i] = 1'b0;
    m_armed = 1'b0; m_old = 1'b0;
    m_r1 = 1'b0; m_r2 = 1'b0; m_coin_prev = 1'b0;
    m_left = 0; m_edges = 0;
  endtask

  // Expected outputs after the coming edge, then the key-state update.
  task automatic model_step();
    logic [15:0] jm;
    logic [12:0] e;
    bit raw;
    bit coin_n;
    int ent;
    jm = nx_j0 | nx_j1;
    e = '0;
    for (int i = 0; i < 17; i++)
      if (m_lat[i] && tab_bit[i] >= 0) e[tab_bit[i]] = 1'b1;
    if (jm[3]) begin e[12] = 1'b1; e[7] = 1'b1; end
    if (jm[2]) begin e[11] = 1'b1; e[6] = 1'b1; end
    if (jm[1]) begin e[10] = 1'b1; e[5] = 1'b1; end
    if (jm[0]) begin e[9]  = 1'b1; e[4] = 1'b1; end
    if (jm[4]) begin e[8]  = 1'b1; e[3] = 1'b1; end
    if (jm[5]) e[2] = 1'b1;
    if (jm[6]) e[1] = 1'b1;
    m_edges++;
`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
    if (nx_af && (((m_edges - 1) / AF_DIV) % 2 == 1)) begin
      e[8] = 1'b0;
      e[3] = 1'b0;
    end
`endif
    raw = m_lat[10] | m_lat[11] | jm[7];
    if (m_r1 && !m_r2 && !m_coin_prev) m_left = COIN_N;
    coin_n = (m_left > 0);
    if (m_left > 0) m_left--;
    e[0] = coin_n;
    m_r2 = m_r1;
    m_r1 = raw;
    m_coin_prev = coin_n;
    exp_q.push_back(e);
    if (!m_armed) begin
      m_armed = 1'b1;
      m_old = nx_ps2[10];
    end else if (nx_ps2[10] != m_old) begin
      m_old = nx_ps2[10];
      ent = lookup(nx_ps2[8:0]);
      if (ent >= 0) m_lat[ent] = nx_ps2[9];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_sys);
    ps2_key    = nx_ps2;
    joystick_0 = nx_j0;
    joystick_1 = nx_j1;
`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
    autofire_on = nx_af;
`endif
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ps2_ev(input logic pressed, input logic [8:0] code);
    nx_ps2 = {~nx_ps2[10], pressed, code};
    tick();
  endtask

  // ---------------- main sequence ----------------
  logic [8:0] dir_codes [13] = '{9'h005, 9'h016, 9'h006, 9'h01E, 9'h02D, 9'h02B,
                                 9'h023, 9'h034, 9'h01C, 9'h02E, 9'h036, 9'h0FF,
                                 9'h129};

  initial begin
    reset = 1'b1;
    nx_ps2 = 11'h400;
    nx_j0 = '0;
    nx_j1 = '0;
    ps2_key = nx_ps2;
    joystick_0 = '0;
    joystick_1 = '0;
`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
    nx_af = 1'b0;
    autofire_on = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk_sys);
    #3;
    check("reset_outputs", act, 13'd0);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Arming with the toggle bit already high: nothing may change.
    idle(4);

    // up1 via plain and extended 0x75.
    ps2_ev(1'b1, 9'h075); idle(3);
    ps2_ev(1'b1, 9'h175); idle(3);
    ps2_ev(1'b0, 9'h075); idle(3);

    // fire1 from two independent keys.
    ps2_ev(1'b1, 9'h029); idle(2);
    ps2_ev(1'b1, 9'h114); idle(2);
    ps2_ev(1'b0, 9'h029); idle(3);
    ps2_ev(1'b0, 9'h114); idle(3);

    // Start, player-2, coin keys and unmapped codes.
    for (int i = 0; i < 13; i++) begin
      ps2_ev(1'b1, dir_codes[i]); idle(2);
      ps2_ev(1'b0, dir_codes[i]); idle(COIN_N + 4);
    end

    // Joystick coin: single cycle, long hold, retrigger inside the pulse.
    nx_j1[7] = 1'b1; tick(); nx_j1[7] = 1'b0; idle(12);
    nx_j1[7] = 1'b1; idle(20); nx_j1[7] = 1'b0; idle(12);
    nx_j1[7] = 1'b1; tick(); nx_j1[7] = 1'b0; idle(3);
    nx_j1[7] = 1'b1; tick(); nx_j1[7] = 1'b0; idle(12);

    // Key release and joystick press on the same line in one cycle.
    ps2_ev(1'b1, 9'h075); idle(2);
    nx_j0[3] = 1'b1; ps2_ev(1'b0, 9'h075); idle(2);
    nx_j0[3] = 1'b0; idle(2);

`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
    nx_af = 1'b1; nx_j0[4] = 1'b1; idle(16);
    nx_af = 1'b0; idle(8);
    nx_j0[4] = 1'b0; idle(2);
`endif

    // Randomized traffic.
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom;
        rb = $urandom;
        nx_j0 = ra[15:0] & rb[15:0];
        nx_j1 = ra[31:16] & rb[31:16];
        if ($urandom_range(0, 7) != 0) begin
          nx_j0[7] = 1'b0;
          nx_j1[7] = 1'b0;
        end
      end
`ifdef ARCADE_INPUT_DECODER_AUTOFIRE_EN
      if ($urandom_range(0, 15) == 0) nx_af = ~nx_af;
`endif
      if ($urandom_range(0, 2) == 0)
        ps2_ev(1'($urandom_range(0, 1)), pool[$urandom_range(0, 26)]);
      else
        tick();
    end

    // Quiet down, then reset in the middle of a coin pulse with up1 held.
    nx_j0 = '0;
    nx_j1 = '0;
    ps2_ev(1'b0, 9'h02E);
    ps2_ev(1'b0, 9'h036);
    idle(COIN_N + 4);
    ps2_ev(1'b1, 9'h075); idle(2);
    nx_j0[7] = 1'b1; tick(); nx_j0[7] = 1'b0; idle(3);
    @(posedge clk_sys);
    #3;
    reset = 1'b1;
    mon_en = 1'b0;
    check_int("queue_drained_before_reset", exp_q.size(), 0);
    #1;
    check("async_reset_outputs", act, 13'd0);
    nx_ps2 = {~nx_ps2[10], 1'b1, 9'h075};
    ps2_key = nx_ps2;
    repeat (2) @(posedge clk_sys);
    #3;
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    // The toggled word seen on the arming edge must not be decoded.
    idle(4);
    ps2_ev(1'b1, 9'h072); idle(3);
    ps2_ev(1'b0, 9'h072); idle(3);

    @(posedge clk_sys);
    #3;
    mon_en = 1'b0;
    check_int("queue_drained_at_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
